// File: rtl/klein_core.sv
// KLEIN-64 iterative encryption core: one round per clock, 12 rounds plus final whitening.
// Optional scope trigger enabled by defining KLEIN_TRIGGER_EN; without it trigger is tied low.
module klein_core #(
    parameter int unsigned BLOCK_W   = 64,
    parameter int unsigned NB_ROUNDS = 12
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [BLOCK_W-1:0] key_i,
    input  logic [BLOCK_W-1:0] data_i,
    output logic [BLOCK_W-1:0] data_o,
    output logic               busy,
    output logic               done,
    output logic               trigger
);

    localparam int unsigned RcW = $clog2(NB_ROUNDS + 1);

    typedef enum logic [1:0] {StIdle, StRound, StFin} state_e;

    state_e             fsm_q, fsm_d;
    logic [BLOCK_W-1:0] st_q, st_d;
    logic [BLOCK_W-1:0] rk_q, rk_d;
    logic [BLOCK_W-1:0] res_q, res_d;
    logic [RcW-1:0]     rc_q, rc_d;
    logic               accept;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h7;  4'h1: y = 4'h4;  4'h2: y = 4'hA;  4'h3: y = 4'h9;
            4'h4: y = 4'h1;  4'h5: y = 4'hF;  4'h6: y = 4'hB;  4'h7: y = 4'h0;
            4'h8: y = 4'hC;  4'h9: y = 4'h3;  4'hA: y = 4'h2;  4'hB: y = 4'h6;
            4'hC: y = 4'h8;  4'hD: y = 4'hE;  4'hE: y = 4'hD;  default: y = 4'h5;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] sub_nibbles(input logic [63:0] s);
        logic [63:0] r;
        for (int n = 0; n < 16; n++) begin
            r[4*n +: 4] = sbox(s[4*n +: 4]);
        end
        return r;
    endfunction

    // Multiply by 02 in GF(2^8) modulo 0x11B
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // AES MixColumns on one 32-bit column, byte 0 in the MSBs
    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [63:0] klein_round(input logic [63:0] s, input logic [63:0] k);
        logic [63:0] t;
        t = sub_nibbles(s ^ k);
        t = {t[47:0], t[63:48]};
        return {mix_col(t[63:32]), mix_col(t[31:0])};
    endfunction

    function automatic logic [63:0] key_sched(input logic [63:0] k, input logic [7:0] i);
        logic [31:0] a, b, na, nb;
        a  = {k[55:32], k[63:56]};
        b  = {k[23:0], k[31:24]};
        na = b;
        nb = a ^ b;
        na[15:8] = na[15:8] ^ i;
        for (int n = 2; n < 6; n++) begin
            nb[4*n +: 4] = sbox(nb[4*n +: 4]);
        end
        return {na, nb};
    endfunction

    // Next-state logic: accept in IDLE/FIN, iterate rounds, capture ciphertext in FIN
    always_comb begin
        fsm_d  = fsm_q;
        st_d   = st_q;
        rk_d   = rk_q;
        rc_d   = rc_q;
        res_d  = res_q;
        accept = 1'b0;
        case (fsm_q)
            StIdle: begin
                accept = start;
            end
            StRound: begin
                st_d = klein_round(st_q, rk_q);
                rk_d = key_sched(rk_q, 8'(rc_q));
                rc_d = rc_q + RcW'(1);
                if (rc_q == RcW'(NB_ROUNDS)) begin
                    fsm_d = StFin;
                end
            end
            StFin: begin
                res_d  = st_q ^ rk_q;
                accept = start;
                fsm_d  = StIdle;
            end
            default: fsm_d = StIdle;
        endcase
        if (accept) begin
            st_d  = data_i;
            rk_d  = key_i;
            rc_d  = RcW'(1);
            fsm_d = StRound;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q <= StIdle;
            st_q  <= '0;
            rk_q  <= '0;
            res_q <= '0;
            rc_q  <= '0;
        end else begin
            fsm_q <= fsm_d;
            st_q  <= st_d;
            rk_q  <= rk_d;
            res_q <= res_d;
            rc_q  <= rc_d;
        end
    end

    // Ciphertext is presented during FIN and held from res_q afterwards
    assign busy   = (fsm_q == StRound);
    assign done   = (fsm_q == StFin);
    assign data_o = done ? (st_q ^ rk_q) : res_q;

`ifdef KLEIN_TRIGGER_EN
    logic trig_q, trig_d;

    // Trigger marks the first ROUND cycle (round 1 being computed)
    always_comb begin
        trig_d = accept;
    end

    // Trigger register
    always_ff @(posedge clock) begin
        if (reset) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= trig_d;
        end
    end

    assign trigger = trig_q;
`else
    assign trigger = 1'b0;
`endif

endmodule

// File: tb/tb_klein_core.sv
// Directed testbench for klein_core using published KLEIN-64 vectors.
module tb_klein_core;

    logic        clock;
    logic        reset;
    logic        start;
    logic [63:0] key_i;
    logic [63:0] data_i;
    logic [63:0] data_o;
    logic        busy;
    logic        done;
    logic        trigger;

    int checks;
    int failures;

    klein_core dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .key_i   (key_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .busy    (busy),
        .done    (done),
        .trigger (trigger)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Trigger expected on the first cycle after acceptance only
    function automatic logic exp_trig(input int k);
`ifdef KLEIN_TRIGGER_EN
        return (k == 1);
`else
        return 1'b0;
`endif
    endfunction

    // Drive a one-cycle start from a negedge; returns at the negedge after the accept edge
    task automatic start_block(input logic [63:0] k, input logic [63:0] d);
        start  = 1'b1;
        key_i  = k;
        data_i = d;
        @(negedge clock);
        start  = 1'b0;
        key_i  = 64'hA5A5_5A5A_0F0F_F0F0;
        data_i = 64'h3C3C_C3C3_9696_6969;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start  = 1'b0;
        key_i  = '0;
        data_i = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (data_o !== 64'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", data_o); end
        checks++; if (trigger !== 1'b0) begin failures++; $display("FAIL reset_trig got=%b exp=0", trigger); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_single();
        int busy_cnt, done_cnt, done_at;
        busy_cnt = 0; done_cnt = 0; done_at = 0;
        start_block(64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int k = 1; k <= 20; k++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
                checks++;
                if (data_o !== 64'hCDC0_B51F_1472_2BBE) begin
                    failures++; $display("FAIL single_data got=%h exp=CDC0B51F14722BBE", data_o);
                end
            end
            checks++;
            if (trigger !== exp_trig(k)) begin
                failures++; $display("FAIL single_trig k=%0d got=%b exp=%b", k, trigger, exp_trig(k));
            end
            @(negedge clock);
        end
        checks++; if (busy_cnt != 12) begin failures++; $display("FAIL single_busy got=%0d exp=12", busy_cnt); end
        checks++; if (done_at != 13) begin failures++; $display("FAIL single_latency got=%0d exp=13", done_at); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL single_donecnt got=%0d exp=1", done_cnt); end
        checks++;
        if (data_o !== 64'hCDC0_B51F_1472_2BBE) begin
            failures++; $display("FAIL single_hold got=%h exp=CDC0B51F14722BBE", data_o);
        end
    endtask

    task automatic test_back_to_back();
        int done_at, busy_cnt, done_cnt;
        done_at = 0; busy_cnt = 0; done_cnt = 0;
        start_block(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000);
        for (int k = 1; k <= 30; k++) begin
            if (done === 1'b1) begin
                done_at = k;
                break;
            end
            @(negedge clock);
        end
        checks++; if (done_at != 13) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=13", done_at); end
        checks++;
        if (data_o !== 64'h6456_764E_8602_E154) begin
            failures++; $display("FAIL b2b_first_data got=%h exp=6456764E8602E154", data_o);
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_fin_busy got=%b exp=0", busy); end
        // Issue the next block during the FIN cycle
        start_block(64'h1234_5678_90AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_no_gap got=%b exp=1", busy); end
        checks++;
        if (data_o !== 64'h6456_764E_8602_E154) begin
            failures++; $display("FAIL b2b_prev_held got=%h exp=6456764E8602E154", data_o);
        end
        done_at = 0;
        for (int k = 1; k <= 20; k++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
                checks++;
                if (data_o !== 64'h5923_56C4_9971_76C8) begin
                    failures++; $display("FAIL b2b_second_data got=%h exp=592356C4997176C8", data_o);
                end
            end
            checks++;
            if (trigger !== exp_trig(k)) begin
                failures++; $display("FAIL b2b_trig k=%0d got=%b exp=%b", k, trigger, exp_trig(k));
            end
            @(negedge clock);
        end
        checks++; if (done_at != 13) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=13", done_at); end
        checks++; if (busy_cnt != 12) begin failures++; $display("FAIL b2b_busy got=%0d exp=12", busy_cnt); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL b2b_donecnt got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_start_while_busy();
        int done_at, done_cnt;
        done_at = 0; done_cnt = 0;
        start_block(64'h0000_0000_0000_0000, 64'h1234_5678_90AB_CDEF);
        for (int k = 1; k <= 25; k++) begin
            if (k == 5) begin
                start  = 1'b1;
                key_i  = 64'hFFFF_0000_FFFF_0000;
                data_i = 64'h0123_4567_89AB_CDEF;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
                checks++;
                if (data_o !== 64'h629F_9D6D_FF95_800E) begin
                    failures++; $display("FAIL ignore_data got=%h exp=629F9D6DFF95800E", data_o);
                end
            end
            checks++;
            if (trigger !== exp_trig(k)) begin
                failures++; $display("FAIL ignore_trig k=%0d got=%b exp=%b", k, trigger, exp_trig(k));
            end
            @(negedge clock);
        end
        start = 1'b0;
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL ignore_donecnt got=%0d exp=1", done_cnt); end
        checks++; if (done_at != 13) begin failures++; $display("FAIL ignore_latency got=%0d exp=13", done_at); end
    endtask

    task automatic test_reset_abort();
        int done_cnt, busy_cnt, done_at;
        done_cnt = 0; busy_cnt = 0; done_at = 0;
        start_block(64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (6) @(negedge clock);
        // Now in the cycle where round 7 is computed
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", done); end
        checks++; if (data_o !== 64'h0) begin failures++; $display("FAIL abort_data got=%h exp=0", data_o); end
        checks++; if (trigger !== 1'b0) begin failures++; $display("FAIL abort_trig got=%b exp=0", trigger); end
        for (int k = 1; k <= 20; k++) begin
            if (done === 1'b1) done_cnt++;
            if (busy === 1'b1) busy_cnt++;
            @(negedge clock);
        end
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL abort_nodone got=%0d exp=0", done_cnt); end
        checks++; if (busy_cnt != 0) begin failures++; $display("FAIL abort_nobusy got=%0d exp=0", busy_cnt); end
        start_block(64'h1234_5678_90AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int k = 1; k <= 20; k++) begin
            if (done === 1'b1 && done_at == 0) begin
                done_at = k;
                checks++;
                if (data_o !== 64'h5923_56C4_9971_76C8) begin
                    failures++; $display("FAIL abort_fresh_data got=%h exp=592356C4997176C8", data_o);
                end
            end
            @(negedge clock);
        end
        checks++; if (done_at != 13) begin failures++; $display("FAIL abort_fresh_latency got=%0d exp=13", done_at); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        key_i    = '0;
        data_i   = '0;
        @(negedge clock);
        test_reset();
        test_single();
        test_back_to_back();
        test_start_while_busy();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
